// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Purpose  : Round-robin arbiter sharing one downstream resource among WIDTH
//            requesters. A rotating-priority first-set-bit search starts at a
//            moving pointer. A grant is held until the owner raises done_i;
//            back-to-back grants are issued with no idle bubble.
// Options  : `define RR_ARB_TIMEOUT_EN builds a grant watchdog. A grant that
//            has been held for TIMEOUT cycles is force-released and timeout_o
//            pulses for one cycle. Without the macro timeout_o is tied to 0.
// Ports    : clk_i        - clock, rising edge
//            arst_n_i     - asynchronous active-low reset
//            req_i        - request vector, bit n = requester n
//            done_i       - owner releases the grant (used only while granted)
//            grant_o      - one-hot grant vector, zero when idle
//            grant_idx_o  - index of granted requester, 0 when idle
//            grant_val_o  - a grant is active
//            timeout_o    - one-cycle pulse after a watchdog forced release
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [WIDTH-1:0]         req_i,
  input  logic                     done_i,
  output logic [WIDTH-1:0]         grant_o,
  output logic [$clog2(WIDTH)-1:0] grant_idx_o,
  output logic                     grant_val_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(WIDTH);

  // Elaboration-time guard on the legal parameter range.
  if (WIDTH < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("rr_grant_arbiter: WIDTH and TIMEOUT must both be 2 or more");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  grant_q, grant_d;
  logic              val_q, val_d;

  logic              force_rel;   // watchdog release this cycle
  logic              release_now; // owner gives up the grant this cycle
  logic              new_grant;   // a grant (possibly to the same owner) starts next cycle
  logic [IW-1:0]     rel_ptr;     // pointer value after releasing the current owner
  logic [IW-1:0]     sel_base;
  logic [IW:0]       sel_res;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;

  // Rotating first-set-bit search. Walking the offsets from high to low lets
  // the smallest offset (closest to base) overwrite any later hit, so no
  // break is needed and the loop stays a plain priority chain.
  function automatic logic [IW:0] rr_select(input logic [IW-1:0]    base,
                                            input logic [WIDTH-1:0] req);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      pos = {1'b0, base} + (IW+1)'(k);
      if (pos >= (IW+1)'(WIDTH)) begin
        pos = pos - (IW+1)'(WIDTH);
      end
      if (req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign rel_ptr     = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + 1'b1;
  assign release_now = (state_q == S_GRANT) && (done_i || force_rel);
  // On a release the search must already use the advanced pointer so the
  // next owner is chosen in the same cycle.
  assign sel_base    = release_now ? rel_ptr : ptr_q;
  assign sel_res     = rr_select(sel_base, req_i);
  assign sel_found   = sel_res[IW];
  assign sel_idx     = sel_res[IW-1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    val_d     = val_q;
    new_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d   = S_GRANT;
          idx_d     = sel_idx;
          grant_d   = WIDTH'(1) << sel_idx;
          val_d     = 1'b1;
          new_grant = 1'b1;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_d = rel_ptr;
          if (sel_found) begin
            idx_d     = sel_idx;
            grant_d   = WIDTH'(1) << sel_idx;
            val_d     = 1'b1;
            new_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            grant_d = '0;
            val_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        grant_d = '0;
        val_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      val_q   <= val_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // The counter holds the number of cycles the current grant has already
  // been visible minus one, so reaching TIMEOUT-1 means this is its last cycle.
  // A simultaneous done_i wins, making that case a normal release.
  assign force_rel = (state_q == S_GRANT) && !done_i &&
                     (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (new_grant) begin
      cnt_d = '0;
    end else if (state_q == S_GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= force_rel;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_val_o = val_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_arbiter
// Purpose  : Self-checking bench for rr_grant_arbiter (WIDTH=16, TIMEOUT=8).
//            Directed scenarios plus randomized traffic against a behavioural
//            round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

  localparam int W  = 16;
  localparam int TO = 8;
  localparam int IW = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [W-1:0]  req = '0;
  logic          done = 1'b0;
  logic [W-1:0]  grant_o;
  logic [IW-1:0] grant_idx_o;
  logic          grant_val_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_ptr, m_idx, m_cnt;
  bit m_val, m_to;

  rr_grant_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .req_i       (req),
    .done_i      (done),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_val_o (grant_val_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_pick(input int base, input logic [W-1:0] r);
    for (int i = 0; i < W; i++) begin
      if (r[(base + i) % W]) return (base + i) % W;
    end
    return -1;
  endfunction

  function automatic logic [W+IW+1:0] model_out();
    logic [W-1:0] g;
    g = m_val ? (W'(1) << m_idx) : '0;
    return {g, IW'(m_val ? m_idx : 0), m_val, m_to};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_cnt = 0; m_val = 0; m_to = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit forced;
    int n;
    if (!m_val) begin
      m_to = 0;
      n = ref_pick(m_ptr, req);
      if (n >= 0) begin m_val = 1; m_idx = n; m_cnt = 0; end
    end else begin
      forced = TO_EN && (m_cnt == TO - 1) && !done;
      if (done || forced) begin
        m_ptr = (m_idx + 1) % W;
        n = ref_pick(m_ptr, req);
        if (n >= 0) begin m_idx = n; m_cnt = 0; end
        else begin m_val = 0; m_idx = 0; end
        m_to = forced;
      end else begin
        m_cnt++;
        m_to = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    req    = '0;
    done   = 1'b0;
    model_reset();
    #2;
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req = 16'h0001;
    tick();
    n_checks++;
    if (grant_o !== 16'h0001 || grant_val_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_grant: grant=%h val=%b expected grant=0001 val=1", grant_o, grant_val_o);
    end
    #2;
    arst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({grant_o, grant_idx_o, grant_val_o, timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async_clear: grant=%h idx=%0d val=%b to=%b expected all 0",
               grant_o, grant_idx_o, grant_val_o, timeout_o);
    end
    @(posedge clk);
    #3;
    arst_n = 1'b1;
    req = 16'h8001;
    tick();
    n_checks++;
    if (grant_o !== 16'h0001 || grant_idx_o !== 4'd0 || grant_val_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%h idx=%0d expected grant=0001 idx=0", grant_o, grant_idx_o);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 16'h0840;
    tick();
    n_checks++;
    if (grant_o !== 16'h0040 || grant_idx_o !== 4'd6) begin
      n_fail++;
      $display("FAIL rot_first: grant=%h idx=%0d expected grant=0040 idx=6", grant_o, grant_idx_o);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant_o !== 16'h0800 || grant_idx_o !== 4'd11) begin
      n_fail++;
      $display("FAIL rot_second: grant=%h idx=%0d expected grant=0800 idx=11", grant_o, grant_idx_o);
    end
    tick();
    n_checks++;
    if (grant_o !== 16'h0800) begin
      n_fail++;
      $display("FAIL rot_hold: grant=%h expected 0800", grant_o);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant_o !== 16'h0040 || grant_idx_o !== 4'd6) begin
      n_fail++;
      $display("FAIL rot_wrap: grant=%h idx=%0d expected grant=0040 idx=6", grant_o, grant_idx_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req  = 16'hFFFF;
    done = 1'b1;
    for (int i = 0; i <= W; i++) begin
      tick();
      n_checks++;
      if (grant_val_o !== 1'b1 || grant_idx_o !== IW'(i % W) || grant_o !== (W'(1) << (i % W))) begin
        n_fail++;
        $display("FAIL b2b_step%0d: val=%b idx=%0d grant=%h expected val=1 idx=%0d",
                 i, grant_val_o, grant_idx_o, grant_o, i % W);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_idle_done();
    do_reset();
    req = 16'h0008;
    tick();
    done = 1'b1;
    req  = '0;
    tick();
    // pointer is now 4; done activity while idle must not move it
    for (int i = 0; i < 6; i++) begin
      done = i[0];
      tick();
      n_checks++;
      if (grant_val_o !== 1'b0 || grant_o !== '0) begin
        n_fail++;
        $display("FAIL idle_done%0d: val=%b grant=%h expected val=0 grant=0000", i, grant_val_o, grant_o);
      end
    end
    done = 1'b0;
    req  = 16'h0014;
    tick();
    n_checks++;
    if (grant_idx_o !== 4'd4 || grant_o !== 16'h0010) begin
      n_fail++;
      $display("FAIL idle_ptr_kept: idx=%0d grant=%h expected idx=4 grant=0010", grant_idx_o, grant_o);
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req = 16'h0100;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant_idx_o !== 4'd8 || grant_val_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_regrant: idx=%0d val=%b expected idx=8 val=1", grant_idx_o, grant_val_o);
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (grant_o !== 16'h0100) begin
        n_fail++;
        $display("FAIL single_hold%0d: grant=%h expected 0100", i, grant_o);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant_val_o !== 1'b0 || grant_o !== '0 || grant_idx_o !== '0) begin
      n_fail++;
      $display("FAIL single_release: val=%b grant=%h idx=%0d expected all 0", grant_val_o, grant_o, grant_idx_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0003;
    for (int t = 1; t <= TO; t++) begin
      tick();
      n_checks++;
      if (grant_o !== 16'h0001 || timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold_c%0d: grant=%h to=%b expected grant=0001 to=0", t, grant_o, timeout_o);
      end
    end
    tick();
`ifdef RR_ARB_TIMEOUT_EN
    n_checks++;
    if (grant_o !== 16'h0002 || timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_forced: grant=%h to=%b expected grant=0002 to=1", grant_o, timeout_o);
    end
    tick();
    n_checks++;
    if (grant_o !== 16'h0002 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse_end: grant=%h to=%b expected grant=0002 to=0", grant_o, timeout_o);
    end
`else
    tick();
    n_checks++;
    if (grant_o !== 16'h0001 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_disabled: grant=%h to=%b expected grant=0001 to=0", grant_o, timeout_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [W+IW+1:0] exp_v;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = W'($urandom & $urandom);
      done = ($urandom_range(0, 2) == 0);
      tick();
      exp_v = model_out();
      n_checks++;
      if ({grant_o, grant_idx_o, grant_val_o, timeout_o} !== exp_v) begin
        n_fail++;
        $display("FAIL rand_c%0d: got grant=%h idx=%0d val=%b to=%b expected grant=%h idx=%0d val=%b to=%b",
                 c, grant_o, grant_idx_o, grant_val_o, timeout_o,
                 exp_v[W+IW+1:IW+2], exp_v[IW+1:2], exp_v[1], exp_v[0]);
      end
      n_checks++;
      if ($countones(grant_o) > 1 || grant_val_o !== (|grant_o)) begin
        n_fail++;
        $display("FAIL rand_onehot_c%0d: grant=%h val=%b expected one-hot with val=OR", c, grant_o, grant_val_o);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({grant_o, grant_idx_o, grant_val_o, timeout_o} !== '0) begin
          n_fail++;
          $display("FAIL rand_reset_c%0d: grant=%h val=%b expected all 0", c, grant_o, grant_val_o);
        end
        #1;
        arst_n = 1'b1;
      end
    end
    req  = '0;
    done = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    test_rotation();
    test_back_to_back();
    test_idle_done();
    test_single_requester();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
